mc_control_fsm: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 116 +++++++++++
 rtl/mc_control_fsm_wait_cnt.sv | 24 ++
 rtl/mc_control_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared state, instruction-class and mux/ALU encodings for the multicycle MIPS control unit.
// MC_CTRL_MULDIV_EN adds mult/div/mfhi/mflo to the instruction decode.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST_SP  = 5'd0,
    S_FETCH   = 5'd1,
    S_DECODE  = 5'd2,
    S_EXEC_R  = 5'd3,
    S_EXEC_I  = 5'd4,
    S_WB      = 5'd5,
    S_ADDR    = 5'd6,
    S_MEM_RD  = 5'd7,
    S_MEM_WB  = 5'd8,
    S_MEM_WR  = 5'd9,
    S_BRANCH  = 5'd10,
    S_JUMP    = 5'd11,
    S_EXC     = 5'd12,
    S_EXC_JMP = 5'd13,
    S_MULDIV  = 5'd14
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_J,
    C_MULT, C_DIV, C_MFHI, C_MFLO, C_ILL
  } ins_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_4      = 3'b001;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH = 3'b011;

  localparam logic [2:0] IORD_PC     = 3'b000;
  localparam logic [2:0] IORD_ALUOUT = 3'b001;
  localparam logic [2:0] IORD_EXC    = 3'b010;

  localparam logic [2:0] PCSRC_ALU    = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_MDR    = 3'b011;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_SP = 2'b10;

  localparam logic [3:0] TOREG_ALUOUT = 4'b0000;
  localparam logic [3:0] TOREG_MDR    = 4'b0001;
  localparam logic [3:0] TOREG_HI     = 4'b0010;
  localparam logic [3:0] TOREG_LO     = 4'b0011;
  localparam logic [3:0] TOREG_SP     = 4'b0100;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_NOOP = 2'b10;

  function automatic ins_t decode_ins(input logic [5:0] opcode, input logic [5:0] funct);
    ins_t c;
    c = C_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  c = C_ADD;
          FN_SUB:  c = C_SUB;
          FN_AND:  c = C_AND;
`ifdef MC_CTRL_MULDIV_EN
          FN_MULT: c = C_MULT;
          FN_DIV:  c = C_DIV;
          FN_MFHI: c = C_MFHI;
          FN_MFLO: c = C_MFLO;
`endif
          default: c = C_ILL;
        endcase
      end
      OP_ADDI: c = C_ADDI;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_BEQ:  c = C_BEQ;
      OP_BNE:  c = C_BNE;
      OP_J:    c = C_J;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic is_arith(input ins_t c);
    return (c == C_ADD) || (c == C_SUB) || (c == C_ADDI);
  endfunction

  function automatic logic is_rtype(input ins_t c);
    return (c == C_ADD) || (c == C_SUB) || (c == C_AND) || (c == C_MFHI) || (c == C_MFLO);
  endfunction

endpackage

// File: rtl/mc_control_fsm_wait_cnt.sv
// Saturating 4-bit wait counter: load sets it to 1, otherwise it counts up to 15 and holds.
// last flags the cycle in which the count equals MEM_WAIT.
module mc_wait_cnt #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic [3:0] cnt,
  output logic       last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= 4'd0;
    else if (load)
      cnt <= 4'd1;
    else if (cnt != 4'hF)
      cnt <= cnt + 4'd1;
  end

  assign last = (cnt == 4'(MEM_WAIT));

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit: state register plus Moore output decode, outputs forced low while reset is high.
// Optional MC_CTRL_MULDIV_EN adds the iterative mult/div handshake (MULDIV state, hi/lo writes).
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT  = 1,
  parameter int STACK_REG = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       OV,
  input  logic       ZR,
  input  logic       muldiv_done,
  output logic       pc_write,
  output logic       ir_write,
  output logic       a_write,
  output logic       b_write,
  output logic       mdr_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       mem_wr,
  output logic       epc_write,
  output logic       hi_write,
  output logic       lo_write,
  output logic       muldiv_start,
  output logic [1:0] alu_srcA,
  output logic [2:0] alu_srcB,
  output logic [2:0] alu_op,
  output logic [2:0] iord,
  output logic [2:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [3:0] mem_toreg,
  output logic [1:0] except,
  output logic [4:0] state
);

  state_t     state_q;
  ins_t       cls_q;
  ins_t       dec_cls;
  logic       exc_wait;
  logic       hold;
  logic [3:0] cnt;
  logic       last;

  // STACK_REG is consumed by the datapath register-file mux, not by the sequencing here.
  logic [4:0] unused_stack_reg;
  assign unused_stack_reg = 5'(STACK_REG);

  assign dec_cls = decode_ins(OPCODE, FUNCT);
  assign state   = state_q;

  // The counter reloads on every state change; EXC also reloads after its EPC cycle.
  always_comb begin
    hold = 1'b0;
    case (state_q)
      S_FETCH, S_MEM_RD, S_MEM_WR: hold = !last;
      S_EXC:                       hold = exc_wait && !last;
`ifdef MC_CTRL_MULDIV_EN
      S_MULDIV:                    hold = (cnt == 4'd1) || !muldiv_done;
`endif
      default:                     hold = 1'b0;
    endcase
  end

`ifndef MC_CTRL_MULDIV_EN
  logic unused_muldiv_done;
  assign unused_muldiv_done = muldiv_done;
`endif

  mc_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (!hold),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RST_SP;
      cls_q    <= C_ILL;
      exc_wait <= 1'b0;
    end else begin
      exc_wait <= (state_q == S_EXC);
      case (state_q)
        S_RST_SP: state_q <= S_FETCH;
        S_FETCH:  if (last) state_q <= S_DECODE;
        S_DECODE: begin
          cls_q <= dec_cls;
          case (dec_cls)
            C_ADD, C_SUB, C_AND: state_q <= S_EXEC_R;
            C_ADDI:              state_q <= S_EXEC_I;
            C_LW, C_SW:          state_q <= S_ADDR;
            C_BEQ, C_BNE:        state_q <= S_BRANCH;
            C_J:                 state_q <= S_JUMP;
`ifdef MC_CTRL_MULDIV_EN
            C_MULT, C_DIV:       state_q <= S_MULDIV;
            C_MFHI, C_MFLO:      state_q <= S_WB;
`endif
            default:             state_q <= S_EXC;
          endcase
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_WB;
        S_WB:      state_q <= (OV && is_arith(cls_q)) ? S_EXC : S_FETCH;
        S_ADDR:    state_q <= (cls_q == C_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  if (last) state_q <= S_MEM_WB;
        S_MEM_WB:  state_q <= S_FETCH;
        S_MEM_WR:  if (last) state_q <= S_FETCH;
        S_BRANCH:  state_q <= S_FETCH;
        S_JUMP:    state_q <= S_FETCH;
        S_EXC:     if (exc_wait && last) state_q <= S_EXC_JMP;
        S_EXC_JMP: state_q <= S_FETCH;
`ifdef MC_CTRL_MULDIV_EN
        S_MULDIV:  if ((cnt != 4'd1) && muldiv_done) state_q <= S_FETCH;
`endif
        default:   state_q <= S_RST_SP;
      endcase
    end
  end

  always_comb begin
    pc_write = 1'b0; ir_write = 1'b0; a_write = 1'b0; b_write = 1'b0;
    mdr_write = 1'b0; aluout_write = 1'b0; reg_write = 1'b0; mem_wr = 1'b0;
    epc_write = 1'b0; hi_write = 1'b0; lo_write = 1'b0; muldiv_start = 1'b0;
    alu_srcA = SRCA_PC; alu_srcB = SRCB_B; alu_op = 3'b000; iord = IORD_PC;
    pc_src = PCSRC_ALU; reg_dst = RDST_RT; mem_toreg = TOREG_ALUOUT; except = EXC_NONE;
    if (!reset) begin
      case (state_q)
        S_RST_SP: begin
          reg_write = 1'b1; reg_dst = RDST_SP; mem_toreg = TOREG_SP;
        end
        S_FETCH: begin
          alu_srcB = SRCB_4; alu_op = ALU_ADD;
          if (last) begin
            ir_write = 1'b1; pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          a_write = 1'b1; b_write = 1'b1; alu_srcB = SRCB_IMM_SH;
          alu_op = ALU_ADD; aluout_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_srcA = SRCA_A; aluout_write = 1'b1;
          alu_op = (cls_q == C_SUB) ? ALU_SUB : (cls_q == C_AND) ? ALU_AND : ALU_ADD;
        end
        S_EXEC_I: begin
          alu_srcA = SRCA_A; alu_srcB = SRCB_IMM; alu_op = ALU_ADD; aluout_write = 1'b1;
        end
        S_WB: begin
          if (!(OV && is_arith(cls_q))) begin
            reg_write = 1'b1;
            reg_dst   = is_rtype(cls_q) ? RDST_RD : RDST_RT;
            mem_toreg = (cls_q == C_MFHI) ? TOREG_HI :
                        (cls_q == C_MFLO) ? TOREG_LO : TOREG_ALUOUT;
          end
        end
        S_ADDR: begin
          alu_srcA = SRCA_A; alu_srcB = SRCB_IMM; alu_op = ALU_ADD; aluout_write = 1'b1;
        end
        S_MEM_RD: begin
          iord = IORD_ALUOUT; mdr_write = last;
        end
        S_MEM_WB: begin
          reg_write = 1'b1; reg_dst = RDST_RT; mem_toreg = TOREG_MDR;
        end
        S_MEM_WR: begin
          iord = IORD_ALUOUT; mem_wr = 1'b1;
        end
        S_BRANCH: begin
          alu_srcA = SRCA_A; alu_op = ALU_SUB;
          if (((cls_q == C_BEQ) && ZR) || ((cls_q == C_BNE) && !ZR)) begin
            pc_write = 1'b1; pc_src = PCSRC_ALUOUT;
          end
        end
        S_JUMP: begin
          pc_write = 1'b1; pc_src = PCSRC_JUMP;
        end
        S_EXC: begin
          except = (cls_q == C_ILL) ? EXC_NOOP : EXC_OVF;
          if (!exc_wait) begin
            epc_write = 1'b1; alu_srcB = SRCB_4; alu_op = ALU_SUB;
          end else begin
            iord = IORD_EXC; mdr_write = last;
          end
        end
        S_EXC_JMP: begin
          pc_write = 1'b1; pc_src = PCSRC_MDR;
        end
`ifdef MC_CTRL_MULDIV_EN
        S_MULDIV: begin
          muldiv_start = (cnt == 4'd1);
          if ((cnt != 4'd1) && muldiv_done) begin
            hi_write = 1'b1; lo_write = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized instruction stream checked cycle by cycle against a trace model of the control sequence.
`timescale 1ns/1ps
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  localparam int MW = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OPCODE = '0, FUNCT = '0;
  logic       OV = 1'b0, ZR = 1'b0, muldiv_done = 1'b0;
  logic       pc_write, ir_write, a_write, b_write, mdr_write, aluout_write, reg_write;
  logic       mem_wr, epc_write, hi_write, lo_write, muldiv_start;
  logic [1:0] alu_srcA, reg_dst, except;
  logic [2:0] alu_srcB, alu_op, iord, pc_src;
  logic [3:0] mem_toreg;
  logic [4:0] state;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_WAIT(MW), .STACK_REG(29)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .OV(OV), .ZR(ZR),
    .muldiv_done(muldiv_done), .pc_write(pc_write), .ir_write(ir_write),
    .a_write(a_write), .b_write(b_write), .mdr_write(mdr_write),
    .aluout_write(aluout_write), .reg_write(reg_write), .mem_wr(mem_wr),
    .epc_write(epc_write), .hi_write(hi_write), .lo_write(lo_write),
    .muldiv_start(muldiv_start), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_op(alu_op), .iord(iord), .pc_src(pc_src), .reg_dst(reg_dst),
    .mem_toreg(mem_toreg), .except(except), .state(state)
  );

  typedef struct packed {
    logic pc_write, ir_write, a_write, b_write, mdr_write, aluout_write;
    logic reg_write, mem_wr, epc_write, hi_write, lo_write, muldiv_start;
    logic [1:0] srca;
    logic [2:0] srcb, aluop, iord, pcsrc;
    logic [1:0] regdst;
    logic [3:0] toreg;
    logic [1:0] exc;
  } ctl_t;

  typedef enum {K_ADD, K_SUB, K_AND, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_J,
                K_MULT, K_DIV, K_MFHI, K_MFLO, K_ILL} kind_e;

  ctl_t obs;
  assign obs = {pc_write, ir_write, a_write, b_write, mdr_write, aluout_write,
                reg_write, mem_wr, epc_write, hi_write, lo_write, muldiv_start,
                alu_srcA, alu_srcB, alu_op, iord, pc_src, reg_dst, mem_toreg, except};

  int checks = 0;
  int errors = 0;
  int ov_force = 0;
  int zr_force = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h20) return K_ADD;
      if (fn == 6'h22) return K_SUB;
      if (fn == 6'h24) return K_AND;
`ifdef MC_CTRL_MULDIV_EN
      if (fn == 6'h18) return K_MULT;
      if (fn == 6'h1A) return K_DIV;
      if (fn == 6'h10) return K_MFHI;
      if (fn == 6'h12) return K_MFLO;
`endif
      return K_ILL;
    end
    if (op == 6'h08) return K_ADDI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h05) return K_BNE;
    if (op == 6'h02) return K_J;
    return K_ILL;
  endfunction

  task automatic drive();
    OV = (ov_force < 0) ? 1'($urandom_range(0, 1)) : 1'(ov_force);
    ZR = (zr_force < 0) ? 1'($urandom_range(0, 1)) : 1'(zr_force);
    muldiv_done = 1'b0;
  endtask

  // Entered at posedge+1 with inputs already driven; samples at negedge.
  task automatic cyc(input string tag, input ctl_t e);
    @(negedge clk);
    check(tag, {30'b0, obs}, {30'b0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic exc_seq(input logic [1:0] code);
    ctl_t e;
    drive(); e = '0; e.epc_write = 1'b1; e.srcb = 3'b001; e.aluop = 3'b010; e.exc = code;
    cyc("exc_epc", e);
    for (int i = 0; i < MW; i++) begin
      drive(); e = '0; e.iord = 3'b010; e.exc = code; e.mdr_write = (i == MW - 1);
      cyc("exc_vector", e);
    end
    drive(); e = '0; e.pc_write = 1'b1; e.pcsrc = 3'b011;
    cyc("exc_jmp", e);
  endtask

  task automatic wb_seq(input kind_e k);
    ctl_t e;
    logic ovf;
    drive();
    ovf = OV && (k == K_ADD || k == K_SUB || k == K_ADDI);
    e = '0;
    if (!ovf) begin
      e.reg_write = 1'b1;
      e.regdst    = (k == K_ADDI) ? 2'b00 : 2'b01;
      e.toreg     = (k == K_MFHI) ? 4'b0010 : (k == K_MFLO) ? 4'b0011 : 4'b0000;
    end
    cyc(ovf ? "wb_ovf" : "wb", e);
    if (ovf) exc_seq(2'b01);
  endtask

  task automatic run_insn(input logic [5:0] op, input logic [5:0] fn, input int md_wait, input bit abort_wr);
    ctl_t e;
    kind_e k;
    k = classify(op, fn);
    OPCODE = op;
    FUNCT  = fn;
    for (int i = 0; i < MW; i++) begin
      drive(); e = '0; e.srcb = 3'b001; e.aluop = 3'b001;
      if (i == MW - 1) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      cyc("fetch", e);
    end
    drive(); e = '0; e.a_write = 1'b1; e.b_write = 1'b1; e.srcb = 3'b011;
    e.aluop = 3'b001; e.aluout_write = 1'b1;
    cyc("decode", e);
    case (k)
      K_ADD, K_SUB, K_AND, K_ADDI: begin
        drive(); e = '0; e.srca = 2'b01; e.aluout_write = 1'b1;
        e.srcb  = (k == K_ADDI) ? 3'b010 : 3'b000;
        e.aluop = (k == K_SUB) ? 3'b010 : (k == K_AND) ? 3'b011 : 3'b001;
        cyc("exec", e);
        wb_seq(k);
      end
      K_MFHI, K_MFLO: wb_seq(k);
      K_LW, K_SW: begin
        drive(); e = '0; e.srca = 2'b01; e.srcb = 3'b010; e.aluop = 3'b001; e.aluout_write = 1'b1;
        cyc("addr", e);
        for (int i = 0; i < MW; i++) begin
          if (abort_wr && i == 1) begin
            #2 reset = 1'b1;
            #1;
            check("rst_mem_wr", {63'b0, mem_wr}, 64'd0);
            check("rst_async_outputs", {30'b0, obs}, 64'd0);
            return;
          end
          drive(); e = '0; e.iord = 3'b001;
          if (k == K_LW) e.mdr_write = (i == MW - 1);
          else e.mem_wr = 1'b1;
          cyc(k == K_LW ? "mem_rd" : "mem_wr", e);
        end
        if (k == K_LW) begin
          drive(); e = '0; e.reg_write = 1'b1; e.toreg = 4'b0001;
          cyc("mem_wb", e);
        end
      end
      K_BEQ, K_BNE: begin
        drive(); e = '0; e.srca = 2'b01; e.aluop = 3'b010;
        if ((k == K_BEQ && ZR) || (k == K_BNE && !ZR)) begin
          e.pc_write = 1'b1; e.pcsrc = 3'b001;
        end
        cyc("branch", e);
      end
      K_J: begin
        drive(); e = '0; e.pc_write = 1'b1; e.pcsrc = 3'b010;
        cyc("jump", e);
      end
      K_MULT, K_DIV: begin
        drive(); e = '0; e.muldiv_start = 1'b1;
        cyc("md_start", e);
        for (int i = 0; i < md_wait; i++) begin
          drive(); e = '0;
          cyc("md_wait", e);
        end
        drive(); muldiv_done = 1'b1; e = '0; e.hi_write = 1'b1; e.lo_write = 1'b1;
        cyc("md_done", e);
        muldiv_done = 1'b0;
      end
      default: exc_seq(2'b10);
    endcase
  endtask

  task automatic do_reset();
    ctl_t e;
    reset = 1'b1; OV = 1'b0; ZR = 1'b0; muldiv_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", {30'b0, obs}, 64'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    e = '0; e.reg_write = 1'b1; e.regdst = 2'b10; e.toreg = 4'b0100;
    @(negedge clk);
    check("rst_sp", {30'b0, obs}, {30'b0, e});
    @(posedge clk);
    #1;
    check("state_fetch", {59'b0, state}, {59'b0, S_FETCH});
  endtask

  logic [11:0] tbl [16];

  initial begin
    tbl[0]  = {6'h00, 6'h20}; tbl[1]  = {6'h00, 6'h22}; tbl[2]  = {6'h00, 6'h24};
    tbl[3]  = {6'h08, 6'h00}; tbl[4]  = {6'h23, 6'h00}; tbl[5]  = {6'h2B, 6'h00};
    tbl[6]  = {6'h04, 6'h00}; tbl[7]  = {6'h05, 6'h00}; tbl[8]  = {6'h02, 6'h00};
    tbl[9]  = {6'h00, 6'h18}; tbl[10] = {6'h00, 6'h1A}; tbl[11] = {6'h00, 6'h10};
    tbl[12] = {6'h00, 6'h12}; tbl[13] = {6'h3F, 6'h00}; tbl[14] = {6'h00, 6'h2A};
    tbl[15] = {6'h0F, 6'h20};

    do_reset();

    ov_force = 0; run_insn(6'h00, 6'h20, 0, 1'b0);           // add, no overflow
    ov_force = 1; run_insn(6'h00, 6'h22, 0, 1'b0);           // sub overflow -> EPC
    zr_force = 1; run_insn(6'h04, 6'h00, 0, 1'b0);           // beq taken
    zr_force = 0; run_insn(6'h04, 6'h00, 0, 1'b0);           // beq not taken
    run_insn(6'h3F, 6'h00, 0, 1'b0);                         // unknown opcode
    ov_force = 0; run_insn(6'h00, 6'h18, 31, 1'b0);          // mult, done 32 cycles after start
    ov_force = 1; run_insn(6'h00, 6'h24, 0, 1'b0);           // and ignores OV
    run_insn(6'h08, 6'h15, 0, 1'b0);                         // addi overflow
    run_insn(6'h23, 6'h00, 0, 1'b0);                         // lw ignores OV
    ov_force = 0; run_insn(6'h2B, 6'h00, 0, 1'b0);
    zr_force = 0; run_insn(6'h05, 6'h00, 0, 1'b0);           // bne taken
    run_insn(6'h02, 6'h00, 0, 1'b0);

    ov_force = -1; zr_force = -1;
    for (int n = 0; n < 80; n++) begin
      logic [11:0] ent;
      logic [5:0]  fn;
      ent = tbl[$urandom_range(0, 15)];
      fn  = (ent[11:6] == 6'h00) ? ent[5:0] : 6'($urandom);
      run_insn(ent[11:6], fn, $urandom_range(1, 6), 1'b0);
    end

    ov_force = 0;
    run_insn(6'h2B, 6'h00, 0, 1'b1);                         // reset lands mid mem_wr
    do_reset();
    run_insn(6'h00, 6'h20, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
